// File: rtl/chacha_pio_pkg.sv
// rtl/chacha_pio_pkg.sv - shared types and constants for the PIO-facing ChaCha20 block streamer
package chacha_pio_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY    = 3'd1,
    PRESENT = 3'd2,
    ACKLOW  = 3'd3,
    DONE    = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  localparam int CTRL_REQ = 0;
  localparam int CTRL_ACK = 1;

  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_VALID = 1;
  localparam int STATUS_DONE  = 2;
  localparam int STATUS_ERR   = 3;

endpackage

// File: rtl/chacha_block_buffer.sv
// rtl/chacha_block_buffer.sv - keystream block register file, loaded whole, read one word at a time
module chacha_block_buffer #(
  parameter int WORDS  = 16,
  parameter int WORD_W = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [WORDS*WORD_W-1:0]   block_in,
  input  logic [$clog2(WORDS)-1:0]  rd_idx,
  output logic [WORD_W-1:0]         rd_data
);

  logic [WORD_W-1:0] mem [WORDS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < WORDS; k++) mem[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < WORDS; k++) mem[k] <= block_in[k*WORD_W +: WORD_W];
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/chacha_pio_block_streamer.sv
// rtl/chacha_pio_block_streamer.sv - starts one ChaCha20 block and streams it to a PIO host
// under a REQ/ACK level handshake; all outputs registered.
module chacha_pio_block_streamer
  import chacha_pio_pkg::*;
#(
  parameter int WORDS   = 16,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               ctrl_in,
  output logic                     core_start,
  input  logic                     core_done,
  input  logic [WORDS*WORD_W-1:0]  core_block,
  output logic [WORD_W-1:0]        data_word,
  output logic [3:0]               status
);

  localparam int IW = $clog2(WORDS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(WORDS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              req_q, ack_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_q, err_d, done_q, done_d;
  logic              valid_q, valid_d, busy_q, busy_d;
  logic              start_d, load;
  logic [WORD_W-1:0] word_d, rd_data;
  logic              req, ack, req_rise, ack_rise, timed_out;

  assign req       = ctrl_in[CTRL_REQ];
  assign ack       = ctrl_in[CTRL_ACK];
  assign req_rise  = req & ~req_q;
  assign ack_rise  = ack & ~ack_q;
  assign timed_out = (timer_q == TIMER_LAST);

  chacha_block_buffer #(
    .WORDS  (WORDS),
    .WORD_W (WORD_W)
  ) u_buffer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .block_in (core_block),
    .rd_idx   (idx_q),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Timeout outranks everything in BUSY; a REQ drop outranks core_done (block discarded).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_rise) state_d = BUSY;
      BUSY: begin
        if (timed_out)      state_d = DONE;
        else if (!req)      state_d = core_done ? IDLE : DRAIN;
        else if (core_done) state_d = PRESENT;
      end
      PRESENT: begin
        if (!req)           state_d = IDLE;
        else if (ack_rise)  state_d = ACKLOW;
      end
      ACKLOW: begin
        if (!req)           state_d = IDLE;
        else if (!ack)      state_d = (idx_q == IDX_LAST) ? DONE : PRESENT;
      end
      DONE:    if (!req) state_d = IDLE;
      DRAIN:   if (timed_out || core_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d = 1'b0;
    load    = 1'b0;
    idx_d   = idx_q;
    timer_d = timer_q;
    word_d  = data_word;
    err_d   = err_q;
    done_d  = done_q;
    valid_d = 1'b0;
    busy_d  = state_d inside {BUSY, PRESENT, ACKLOW, DRAIN};
    case (state_q)
      IDLE: begin
        if (req_rise) begin
          start_d = 1'b1;
          err_d   = 1'b0;
          done_d  = 1'b0;
          timer_d = '0;
          idx_d   = '0;
        end
      end
      BUSY: begin
        timer_d = timer_q + 1'b1;
        if (timed_out) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end else if (req && core_done) begin
          load    = 1'b1;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      PRESENT: begin
        if (!req) begin
          idx_d = '0;
        end else if (!ack_rise) begin
          valid_d = 1'b1;
          word_d  = rd_data;
        end
      end
      ACKLOW: begin
        if (!req) begin
          idx_d = '0;
        end else if (!ack) begin
          if (idx_q == IDX_LAST) done_d = 1'b1;
          else                   idx_d  = idx_q + 1'b1;
        end
      end
      DONE:  if (!req) done_d = 1'b0;
      DRAIN: begin
        timer_d = timer_q + 1'b1;
        if (timed_out) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
      idx_q      <= '0;
      timer_q    <= '0;
      core_start <= 1'b0;
      data_word  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      req_q      <= req;
      ack_q      <= ack;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      core_start <= start_d;
      data_word  <= word_d;
      err_q      <= err_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign status[STATUS_BUSY]  = busy_q;
  assign status[STATUS_VALID] = valid_q;
  assign status[STATUS_DONE]  = done_q;
  assign status[STATUS_ERR]   = err_q;

endmodule

// File: tb/tb_chacha_pio_block_streamer.sv
// tb/tb_chacha_pio_block_streamer.sv - directed/random bench for chacha_pio_block_streamer
module tb_chacha_pio_block_streamer;

  localparam int WORDS  = 16;
  localparam int WORD_W = 32;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [1:0]              ctrl_in, to_ctrl;
  logic                    core_done, to_done;
  logic [WORDS*WORD_W-1:0] core_block, to_block;
  logic                    core_start, to_start;
  logic [WORD_W-1:0]       data_word, to_word;
  logic [3:0]              status, to_status;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WORD_W-1:0] exp_words [WORDS];

  always #5 clk = ~clk;

  chacha_pio_block_streamer #(.WORDS(WORDS), .WORD_W(WORD_W), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .core_start(core_start),
    .core_done(core_done), .core_block(core_block), .data_word(data_word), .status(status)
  );

  chacha_pio_block_streamer #(.WORDS(WORDS), .WORD_W(WORD_W), .TIMEOUT(8)) dut_to (
    .clk(clk), .reset_n(reset_n), .ctrl_in(to_ctrl), .core_start(to_start),
    .core_done(to_done), .core_block(to_block), .data_word(to_word), .status(to_status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic make_block(input bit pattern);
    for (int k = 0; k < WORDS; k++) begin
      exp_words[k] = pattern ? 32'hA000_0000 + k : $urandom;
      core_block[k*WORD_W +: WORD_W] = exp_words[k];
    end
  endtask

  task automatic wait_valid(input logic v, input string tag);
    int cyc = 0;
    while (status[1] !== v && cyc < 20) begin tick(); cyc++; end
    check({tag, "_valid"}, {31'd0, status[1]}, {31'd0, v});
  endtask

  task automatic begin_block(input string tag);
    int cyc = 0;
    ctrl_in[0] = 1'b1;
    while (core_start !== 1'b1 && cyc < 8) begin tick(); cyc++; end
    check({tag, "_start"}, {31'd0, core_start}, 32'd1);
    check({tag, "_busy"}, {28'd0, status}, 32'h1);
    tick();
    check({tag, "_start_pulse"}, {31'd0, core_start}, 32'd0);
  endtask

  task automatic finish_core(input int delay);
    tick(delay - 1);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic read_word(input int k, input string tag);
    wait_valid(1'b1, tag);
    check({tag, "_data"}, data_word, exp_words[k]);
    check({tag, "_status"}, {28'd0, status}, 32'h3);
    ctrl_in[1] = 1'b1;
    tick();
    wait_valid(1'b0, {tag, "_ack"});
    ctrl_in[1] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; ctrl_in = 2'b00; to_ctrl = 2'b00;
    core_done = 1'b0; to_done = 1'b0; core_block = '0; to_block = '0;
    tick(2);
    check("reset_status", {28'd0, status}, 32'h0);
    check("reset_data", data_word, 32'h0);
    check("reset_start", {31'd0, core_start}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1. normal block with the A000_000k pattern
    make_block(1'b1);
    begin_block("t1");
    finish_core(10);
    for (int k = 0; k < WORDS; k++) read_word(k, $sformatf("t1_w%0d", k));
    tick();
    check("t1_done", {28'd0, status}, 32'h4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_no_restart", {31'd0, core_start}, 32'd0);
    end
    check("t1_hold_done", {28'd0, status}, 32'h4);
    check("t1_hold_word", data_word, 32'hA000_000F);
    ctrl_in[0] = 1'b0;
    tick();
    check("t1_idle", {28'd0, status}, 32'h0);

    // 2. timeout on the TIMEOUT=8 instance, then a drain timeout
    to_ctrl = 2'b01;
    tick();
    check("t2_start", {31'd0, to_start}, 32'd1);
    check("t2_busy", {28'd0, to_status}, 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t2_waiting", {28'd0, to_status}, 32'h1);
    end
    tick();
    check("t2_timeout", {28'd0, to_status}, 32'hC);
    check("t2_no_word", to_word, 32'h0);
    to_ctrl = 2'b00;
    tick();
    check("t2_err_persist", {28'd0, to_status}, 32'h8);
    to_ctrl = 2'b01;
    tick();
    check("t2_err_clear", {28'd0, to_status}, 32'h1);
    to_ctrl = 2'b00;
    begin
      int cyc = 0;
      tick();
      while (to_status === 4'h1 && cyc < 20) begin tick(); cyc++; end
      check("t2_drain_timeout", {28'd0, to_status}, 32'h8);
    end

    // 3. abort after word 3, restart, then REQ fall with ACK rise
    make_block(1'b0);
    begin_block("t3");
    finish_core(10);
    for (int k = 0; k < 4; k++) read_word(k, $sformatf("t3_w%0d", k));
    ctrl_in[0] = 1'b0;
    tick();
    check("t3_abort", {28'd0, status}, 32'h0);
    make_block(1'b0);
    begin_block("t3r");
    finish_core(4);
    read_word(0, "t3r_w0");
    wait_valid(1'b1, "t3r_w1");
    check("t3r_w1_data", data_word, exp_words[1]);
    ctrl_in = 2'b10;
    tick();
    check("t3_abort_wins", {28'd0, status}, 32'h0);
    ctrl_in = 2'b00;
    tick();

    // 4. drain with REQ re-raised during it, then core_done coinciding with REQ fall
    make_block(1'b0);
    begin_block("t4");
    ctrl_in[0] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_busy", {28'd0, status}, 32'h1);
      if (i == 1) ctrl_in[0] = 1'b1;
      tick();
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("t4_drain_exit", {28'd0, status}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_ignored_req", {29'd0, core_start, status[1:0]}, 32'h0);
    end
    ctrl_in = 2'b00;
    tick();
    begin_block("t4b");
    ctrl_in[0] = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("t4b_done_and_fall", {28'd0, status}, 32'h0);
    tick();
    check("t4b_stays_idle", {28'd0, status}, 32'h0);

    // 5. ACK already high when entering PRESENT
    make_block(1'b0);
    ctrl_in[1] = 1'b1;
    tick();
    begin_block("t5");
    finish_core(6);
    wait_valid(1'b1, "t5_w0");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_stuck_status", {28'd0, status}, 32'h3);
      check("t5_stuck_data", data_word, exp_words[0]);
    end
    ctrl_in[1] = 1'b0;
    tick();
    check("t5_ack_low_hold", {28'd0, status}, 32'h3);
    ctrl_in[1] = 1'b1;
    tick();
    check("t5_ack_rise", {31'd0, status[1]}, 32'd0);
    ctrl_in[1] = 1'b0;
    wait_valid(1'b1, "t5_w1");
    check("t5_w1_data", data_word, exp_words[1]);
    ctrl_in = 2'b00;
    tick();
    check("t5_abort", {28'd0, status}, 32'h0);

    // 6. async reset in ACKLOW at idx 7, then a clean full block
    make_block(1'b0);
    begin_block("t6");
    finish_core(5);
    for (int k = 0; k < 7; k++) read_word(k, $sformatf("t6_w%0d", k));
    wait_valid(1'b1, "t6_w7");
    check("t6_w7_data", data_word, exp_words[7]);
    ctrl_in[1] = 1'b1;
    tick();
    wait_valid(1'b0, "t6_acklow");
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_status", {28'd0, status}, 32'h0);
    check("t6_rst_data", data_word, 32'h0);
    check("t6_rst_start", {31'd0, core_start}, 32'd0);
    tick();
    ctrl_in = 2'b00;
    reset_n = 1'b1;
    tick();
    check("t6_post_reset", {28'd0, status}, 32'h0);
    make_block(1'b0);
    begin_block("t6r");
    finish_core(7);
    for (int k = 0; k < WORDS; k++) read_word(k, $sformatf("t6r_w%0d", k));
    tick();
    check("t6r_done", {28'd0, status}, 32'h4);
    ctrl_in = 2'b00;
    tick();
    check("t6r_idle", {28'd0, status}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
